// File: rtl/four_bit_signed_serial_subtractor_if.sv
// Operand/result bundle for the serial subtractor: master issues start/a/b,
// slave returns the registered difference, flags and handshake status.
interface four_bit_signed_serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ov;
  logic             busy;
  logic             done;

  modport master (output start, a, b, input s, cout, ov, busy, done);
  modport slave  (input start, a, b, output s, cout, ov, busy, done);
endinterface

// File: rtl/four_bit_signed_serial_subtractor.sv
// Bit-serial a - b (a + ~b + 1), LSB first through one gate-level full-adder slice.
//   state | meaning
//   IDLE  | waiting for start; operands latched on the start edge
//   SHIFT | one operand bit per edge; result/flags committed on the last bit
//   DONE  | one-cycle done pulse, then back to IDLE
module four_bit_signed_serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rst_n,
  four_bit_signed_serial_subtractor_if.slave sub
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   d_sh_q, d_sh_d;
  logic               carry_q, carry_d;
  logic               a3_q, a3_d;
  logic               b3_q, b3_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               cout_q, cout_d;
  logic               ov_q, ov_d;

  wire fa_p, fa_sum, fa_g, fa_t, fa_co;
  wire ov_sgn, ov_res, ov_bit;

  xor u_fa_p   (fa_p,   a_sh_q[0], b_sh_q[0]);
  xor u_fa_sum (fa_sum, fa_p,      carry_q);
  and u_fa_g   (fa_g,   a_sh_q[0], b_sh_q[0]);
  and u_fa_t   (fa_t,   fa_p,      carry_q);
  or  u_fa_co  (fa_co,  fa_g,      fa_t);

  // Overflow only when operand signs differ and the result sign departs from a.
  xor u_ov_sgn (ov_sgn, a3_q,   b3_q);
  xor u_ov_res (ov_res, fa_sum, a3_q);
  and u_ov_bit (ov_bit, ov_sgn, ov_res);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      carry_q <= 1'b0;
      a3_q    <= 1'b0;
      b3_q    <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      d_sh_q  <= d_sh_d;
      carry_q <= carry_d;
      a3_q    <= a3_d;
      b3_q    <= b3_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    d_sh_d  = d_sh_q;
    carry_d = carry_q;
    a3_d    = a3_q;
    b3_d    = b3_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (sub.start) begin
          a_sh_d  = sub.a;
          b_sh_d  = ~sub.b;
          a3_d    = sub.a[WIDTH-1];
          b3_d    = sub.b[WIDTH-1];
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        d_sh_d  = {fa_sum, d_sh_q[WIDTH-1:1]};
        carry_d = fa_co;
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          s_d     = {fa_sum, d_sh_q[WIDTH-1:1]};
          cout_d  = fa_co;
          ov_d    = ov_bit;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sub.s    = s_q;
  assign sub.cout = cout_q;
  assign sub.ov   = ov_q;
  assign sub.busy = (state_q != IDLE);
  assign sub.done = (state_q == DONE);
endmodule
